// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder
//   Responder end of the CPU data bus. Decodes a byte address into a
//   word-addressed data RAM or a small set of memory-mapped peripherals:
//   LED register, synchronised switches, an eight-digit seven-segment
//   display scanner and a free-running cycle counter.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   Bus_we     write strobe, one whole word per cycle
//   Bus_addr   byte address, bits [1:0] ignored
//   Bus_wdata  write word
//   Bus_rdata  read word, combinational from Bus_addr
//   sw         board switches (asynchronous)
//   led        LED drive, active-high
//   dig_en     digit enables, active-low one-hot
//   seg        {dp,g,f,e,d,c,b,a}, active-low
module dmem_bus_responder #(
    parameter int RAM_ADDR_W = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Bus_we,
    input  logic [31:0] Bus_addr,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] DIG_WORD = 30'h3FFF_FC00;  // 0xFFFF_F000
    localparam logic [29:0] CYC_WORD = 30'h3FFF_FC08;  // 0xFFFF_F020
    localparam logic [29:0] LED_WORD = 30'h3FFF_FC18;  // 0xFFFF_F060
    localparam logic [29:0] SW_WORD  = 30'h3FFF_FC1C;  // 0xFFFF_F070

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Active-low segment pattern for one hex digit; dp (bit 7) stays off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    logic [29:0]           word_addr;
    logic                  is_io;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  addr_lsb_unused;

    assign word_addr       = Bus_addr[31:2];
    assign is_io           = &Bus_addr[31:12];  // whole 0xFFFF_F000 page
    assign ram_idx         = Bus_addr[RAM_ADDR_W+1:2];
    assign addr_lsb_unused = ^Bus_addr[1:0];

    logic wr_dig, wr_cyc, wr_led;
    assign wr_dig = Bus_we && (word_addr == DIG_WORD);
    assign wr_cyc = Bus_we && (word_addr == CYC_WORD);
    assign wr_led = Bus_we && (word_addr == LED_WORD);

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [31:0] ram [2**RAM_ADDR_W];

    // NOTE: the RAM array has no reset branch so it maps onto block RAM and
    // keeps its contents across reset; rst_n only blocks writes.
    always_ff @(posedge clk) begin
        if (rst_n && Bus_we && !is_io) begin
            ram[ram_idx] <= Bus_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral registers
    // ------------------------------------------------------------------
    logic [31:0] dig_reg;
    logic [31:0] cyc_reg;
    logic [23:0] led_reg;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_reg <= '0;
            cyc_reg <= '0;
            led_reg <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr_dig) dig_reg <= Bus_wdata;
            if (wr_led) led_reg <= Bus_wdata[23:0];
            // A bus write replaces that cycle's increment.
            if (wr_cyc) cyc_reg <= Bus_wdata;
            else        cyc_reg <= cyc_reg + 32'd1;
        end
    end

    assign led = led_reg;

    // ------------------------------------------------------------------
    // Seven-segment scanner
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        dig_idx;
    logic [3:0]        cur_nibble;

    assign cur_nibble = dig_reg[{dig_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            dig_en   <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            // Registered drive: follows the index one clock later, and a
            // DIG write shows up on the next clock without disturbing the slot.
            dig_en <= ~(8'd1 << dig_idx);
            seg    <= hex_to_seg(cur_nibble);
        end
    end

    // ------------------------------------------------------------------
    // Read mux (zero-wait)
    // ------------------------------------------------------------------
    // NOTE: Bus_rdata gets a default before any branch so no latch is inferred.
    always_comb begin
        Bus_rdata = '0;
        if (!is_io) begin
            Bus_rdata = ram[ram_idx];
        end else begin
            case (word_addr)
                DIG_WORD: Bus_rdata = dig_reg;
                CYC_WORD: Bus_rdata = cyc_reg;
                LED_WORD: Bus_rdata = {8'd0, led_reg};
                SW_WORD:  Bus_rdata = {8'd0, sw_sync};
                default:  Bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Self-checking bench for dmem_bus_responder.
//   A behavioural model (edge-count arithmetic for the scanner, flat arrays
//   for RAM, plain registers for the peripherals) is compared against the DUT
//   on every falling edge; directed steps add hand-computed literal checks.
module tb_dmem_bus_responder;

    localparam int RAM_ADDR_W = 14;
    localparam int SCAN_DIV   = 4;
    localparam int RAM_WORDS  = 2**RAM_ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        Bus_we = 1'b0;
    logic [31:0] Bus_addr = '0;
    logic [31:0] Bus_wdata = '0;
    logic [31:0] Bus_rdata;
    logic [23:0] sw = '0;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    dmem_bus_responder #(
        .RAM_ADDR_W(RAM_ADDR_W),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Bus_we   (Bus_we),
        .Bus_addr (Bus_addr),
        .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata),
        .sw       (sw),
        .led      (led),
        .dig_en   (dig_en),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    logic [31:0] m_ram    [RAM_WORDS];
    bit          m_ram_ok [RAM_WORDS];
    logic [31:0] m_dig, m_cyc;
    logic [23:0] m_led, m_sw1, m_sw2;
    logic [7:0]  m_dig_en, m_seg;
    int          m_edges;   // rising edges since reset release

    function automatic int ram_index(input logic [31:0] a);
        return int'((a >> 2) & 32'(RAM_WORDS - 1));
    endfunction

    function automatic int shown_digit();
        return (m_edges / SCAN_DIV) % 8;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dig    <= '0;
            m_cyc    <= '0;
            m_led    <= '0;
            m_sw1    <= '0;
            m_sw2    <= '0;
            m_edges  <= 0;
            m_dig_en <= 8'hFF;
            m_seg    <= 8'hFF;
        end else begin
            m_dig_en <= ~(8'd1 << shown_digit());
            m_seg    <= seg_of(4'((m_dig >> (4 * shown_digit())) & 32'hF));
            m_edges  <= m_edges + 1;
            m_sw1    <= sw;
            m_sw2    <= m_sw1;
            if (Bus_we && (Bus_addr & 32'hFFFF_FFFC) == 32'hFFFF_F020) m_cyc <= Bus_wdata;
            else                                                       m_cyc <= m_cyc + 32'd1;
            if (Bus_we) begin
                if (Bus_addr < 32'hFFFF_F000) begin
                    m_ram[ram_index(Bus_addr)]    <= Bus_wdata;
                    m_ram_ok[ram_index(Bus_addr)] <= 1'b1;
                end else if ((Bus_addr & 32'hFFFF_FFFC) == 32'hFFFF_F000) begin
                    m_dig <= Bus_wdata;
                end else if ((Bus_addr & 32'hFFFF_FFFC) == 32'hFFFF_F060) begin
                    m_led <= Bus_wdata[23:0];
                end
            end
        end
    end

    // Expected read word; returns 0 when the model does not know the value.
    function automatic bit model_rdata(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        v = '0;
        if (a < 32'hFFFF_F000) begin
            v = m_ram[ram_index(a)];
            return m_ram_ok[ram_index(a)];
        end
        if      (w == 32'hFFFF_F000) v = m_dig;
        else if (w == 32'hFFFF_F020) v = m_cyc;
        else if (w == 32'hFFFF_F060) v = {8'd0, m_led};
        else if (w == 32'hFFFF_F070) v = {8'd0, m_sw2};
        return 1'b1;
    endfunction

    logic [31:0] cmp_v;

    always @(negedge clk) begin
        if (checking) begin
            check("led", 32'(led), 32'(m_led));
            check("dig_en", 32'(dig_en), 32'(m_dig_en));
            check("seg", 32'(seg), 32'(m_seg));
            if (model_rdata(Bus_addr, cmp_v)) check("rdata", Bus_rdata, cmp_v);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 2 time units after each rising edge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        Bus_we    = we;
        Bus_addr  = addr;
        Bus_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) m_ram_ok[i] = 1'b0;
        #1 rst_n = 1'b0;
        checking = 1'b1;
        step_n(3);
        rst_n = 1'b1;
        drive(0, 32'hFFFF_F020, 0);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_dig_en", 32'(dig_en), 32'hFF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_cyc", Bus_rdata, 32'h0);

        step_n(10);
        #1 check("cyc_10", Bus_rdata, 32'd10);

        // RAM word, low-bit ignore, aliasing, same-cycle old value
        drive(1, 32'h0000_0104, 32'h1111_1111);
        step();
        drive(1, 32'h0000_0104, 32'hDEAD_BEEF);
        #1 check("ram_same_cycle_old", Bus_rdata, 32'h1111_1111);
        step();
        drive(0, 32'h0000_0104, 0);
        #1 check("ram_104", Bus_rdata, 32'hDEAD_BEEF);
        Bus_addr = 32'h0000_0107;
        #1 check("ram_107", Bus_rdata, 32'hDEAD_BEEF);
        step();
        Bus_addr = 32'h0001_0104;
        #1 check("ram_alias", Bus_rdata, 32'hDEAD_BEEF);

        // LED register
        drive(1, 32'hFFFF_F060, 32'hFF12_3456);
        #1 check("led_rd_old", Bus_rdata, 32'h0);
        step();
        drive(0, 32'hFFFF_F060, 0);
        #1;
        check("led_out", 32'(led), 32'h0012_3456);
        check("led_rd", Bus_rdata, 32'h0012_3456);

        // Unmapped page address: no RAM write through the aliasing index
        drive(1, 32'h0000_F064, 32'h0000_0077);
        step();
        drive(1, 32'hFFFF_F064, 32'h0000_0005);
        step();
        drive(0, 32'hFFFF_F064, 0);
        #1;
        check("unmapped_rd", Bus_rdata, 32'h0);
        check("unmapped_led", 32'(led), 32'h0012_3456);
        Bus_addr = 32'h0000_F064;
        #1 check("unmapped_no_ram", Bus_rdata, 32'h0000_0077);

        // Switch synchroniser
        step();
        sw = 24'hA5_5A0F;
        drive(0, 32'hFFFF_F070, 0);
        #1 check("sw_0edge", Bus_rdata, 32'h0);
        step();
        #1 check("sw_1edge", Bus_rdata, 32'h0);
        step();
        #1 check("sw_2edge", Bus_rdata, 32'h00A5_5A0F);
        drive(1, 32'hFFFF_F070, 32'h0000_1234);
        step();
        drive(0, 32'hFFFF_F070, 0);
        #1 check("sw_ro", Bus_rdata, 32'h00A5_5A0F);

        // Cycle counter write and wrap
        drive(1, 32'hFFFF_F020, 32'hFFFF_FFFE);
        step();
        drive(0, 32'hFFFF_F020, 0);
        #1 check("cyc_wr", Bus_rdata, 32'hFFFF_FFFE);
        step();
        #1 check("cyc_max", Bus_rdata, 32'hFFFF_FFFF);
        step();
        #1 check("cyc_wrap", Bus_rdata, 32'h0);

        // Display scan from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1, 32'hFFFF_F000, 32'hF1A0_9876);
        step();                                   // edge 1
        drive(1, 32'hFFFF_F060, 32'h00AB_CDEF);
        step();                                   // edge 2
        drive(0, 32'hFFFF_F000, 0);
        step_n(2);                                // edge 4
        #1;
        check("d0_en", 32'(dig_en), 32'hFE);
        check("d0_seg", 32'(seg), 32'h82);
        step();                                   // edge 5
        #1;
        check("d1_en", 32'(dig_en), 32'hFD);
        check("d1_seg", 32'(seg), 32'hF8);
        step_n(24);                               // edge 29
        #1;
        check("d7_en", 32'(dig_en), 32'h7F);
        check("d7_seg", 32'(seg), 32'h8E);
        step_n(4);                                // edge 33
        #1;
        check("wrap_en", 32'(dig_en), 32'hFE);
        check("wrap_seg", 32'(seg), 32'h82);
        drive(1, 32'hFFFF_F000, 32'h1234_5670);
        step();                                   // edge 34: DIG written
        drive(0, 32'hFFFF_F000, 0);
        #1 check("dig_wr_old_seg", 32'(seg), 32'h82);
        step();                                   // edge 35
        #1;
        check("dig_wr_new_seg", 32'(seg), 32'hC0);
        check("dig_wr_same_slot", 32'(dig_en), 32'hFE);
        step_n(19);                               // edge 54
        #1;
        check("d5_en", 32'(dig_en), 32'hDF);
        check("d5_seg", 32'(seg), 32'hB0);

        // Reset mid-run with a RAM write strobe held high
        drive(1, 32'h0000_0104, 32'h0BAD_0BAD);
        rst_n = 1'b0;
        #1;
        check("rst_mid_led", 32'(led), 32'h0);
        check("rst_mid_en", 32'(dig_en), 32'hFF);
        check("rst_mid_seg", 32'(seg), 32'hFF);
        step_n(3);
        drive(0, 32'h0000_0104, 0);
        rst_n = 1'b1;
        #1 check("ram_kept", Bus_rdata, 32'hDEAD_BEEF);
        step();
        #1;
        check("restart_en", 32'(dig_en), 32'hFE);
        check("ram_kept2", Bus_rdata, 32'hDEAD_BEEF);
        step_n(2);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
